rv32e_mem_arbiter: RTL

- Round-robin arbiter between N_CORES rv32e cores and a single-ported, synchronous-read shared data RAM.
- Sits directly downstream of each core's data-memory port.
- Serialises load/store requests, issues one RAM access per grant, and returns a one-cycle ack with registered read data to the granted core.
- Core-side protocol is req/ack; RAM side is en/we/addr/wdata with one-cycle read latency.

---
 rtl/rv32e_mem_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/rv32e_mem_arbiter.sv
// rv32e_mem_arbiter
//   Round-robin arbiter between N_CORES rv32e data-memory ports and one
//   single-ported, synchronous-read RAM. Each grant becomes exactly one RAM
//   access. The winning core gets a one-cycle ack, and for loads the
//   registered read data arrives with it.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   core_req    per-core request, held until ack
//   core_we     per-core write enable (1 = store word, 0 = load word)
//   core_addr   per-core byte address, core i at [32*i+31:32*i]
//   core_wdata  per-core store data, same packing
//   core_ack    one-hot, one-cycle completion pulse
//   core_rdata  load data shared by all cores, valid while ack is high
//   mem_en      RAM access enable
//   mem_we      RAM write enable
//   mem_addr    RAM word address
//   mem_wdata   RAM write data
//   mem_rdata   RAM read data, valid the cycle after a read access
module rv32e_mem_arbiter #(
  parameter int N_CORES    = 2,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CORES-1:0]      core_req,
  input  logic [N_CORES-1:0]      core_we,
  input  logic [32*N_CORES-1:0]   core_addr,
  input  logic [32*N_CORES-1:0]   core_wdata,
  output logic [N_CORES-1:0]      core_ack,
  output logic [31:0]             core_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata
);

  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_ACCESS  = 4'b0010,
    S_WAIT    = 4'b0100,
    S_RESPOND = 4'b1000
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic                 we_q, we_d;
  logic [N_CORES-1:0]   core_ack_q, core_ack_d;
  logic [31:0]          core_rdata_q, core_rdata_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;

  // Per-core views of the packed address/data buses.
  logic [31:0] addr_arr  [N_CORES];
  logic [31:0] wdata_arr [N_CORES];

  for (genvar gi = 0; gi < N_CORES; gi++) begin : g_unpack
    assign addr_arr[gi]  = core_addr[32*gi +: 32];
    assign wdata_arr[gi] = core_wdata[32*gi +: 32];
  end

  // Byte-offset bits and bits above the RAM range are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^core_addr;

  // Winner: first requester at or after rr_ptr, wrapping modulo N_CORES.
  // The scan runs from the far end back so the nearest requester wins.
  logic             found;
  logic [IDX_W-1:0] win_idx;

  always_comb begin
    int cand;
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= N_CORES) cand = cand - N_CORES;
      if (core_req[cand]) begin
        found   = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    win_d        = win_q;
    we_d         = we_q;
    core_ack_d   = '0;
    core_rdata_d = core_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d       = win_idx;
          we_d        = core_we[win_idx];
          mem_en_d    = 1'b1;
          mem_we_d    = core_we[win_idx];
          mem_addr_d  = addr_arr[win_idx][ADDR_WIDTH+1:2];
          mem_wdata_d = wdata_arr[win_idx];
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // The RAM samples en/we/addr/wdata at the end of this cycle.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!we_q) core_rdata_d = mem_rdata;
        core_ack_d[win_q] = 1'b1;
        state_d = S_RESPOND;
      end
      S_RESPOND: begin
        rr_ptr_d = (win_q == IDX_W'(N_CORES - 1)) ? '0 : win_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      win_q        <= '0;
      we_q         <= 1'b0;
      core_ack_q   <= '0;
      core_rdata_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      win_q        <= win_d;
      we_q         <= we_d;
      core_ack_q   <= core_ack_d;
      core_rdata_q <= core_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign core_ack   = core_ack_q;
  assign core_rdata = core_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
